// File: rtl/dsp_mac_sequencer.sv
// Operand/control feeder for one DSP58 slice computing R = X*y + Z limb by limb.
// The slice accumulates the inter-limb carry through its P>>17 feedback path.
module dsp_mac_sequencer #(
    parameter int WORD_COUNT = 8,
    parameter int ABREG      = 1,
    parameter int MREG       = 1
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [16:0] y_i,
    output logic        busy_o,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [16:0] x_i,
    input  logic [16:0] z_i,
    output logic [16:0] A_o,
    output logic [16:0] B_o,
    output logic [33:0] C_o,
    output logic        CREG_en_o,
    output logic [8:0]  OPMODE_o,
    input  logic [33:0] P_i,
    output logic        res_valid_o,
    output logic [16:0] res_o,
    output logic        res_last_o,
    output logic        done_o
);

    localparam int DSP_REG_LEVEL = 1 + ABREG + MREG;
    localparam int STAGES        = DSP_REG_LEVEL;
    localparam int OP_DLY        = DSP_REG_LEVEL - 2;
    localparam int CNT_W         = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_J = CNT_W'(WORD_COUNT - 1);

    localparam logic [8:0] OP_LIMB0  = 9'h185;
    localparam logic [8:0] OP_LIMBN  = 9'h1E5;
    localparam logic [8:0] OP_BUBBLE = 9'h020;
    localparam logic [8:0] OP_FLUSH  = 9'h060;
    localparam logic [8:0] OP_IDLE   = 9'h000;

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DRAIN} state_t;

    typedef struct packed {
        logic [8:0]  opmode;
        logic [33:0] c;
        logic        creg_en;
    } ctrl_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [16:0]         y_q;
    logic                hs;
    logic                slot_tag, slot_last;
    logic [16:0]         slot_a, slot_b;
    ctrl_t               slot_ctrl;
    ctrl_t [OP_DLY:0]    ctrl_pipe;
    logic [STAGES:0]     vld_pipe, last_pipe;
    logic                unused_p_hi;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ISSUE;
            ISSUE:   if (hs && cnt_q == LAST_J) state_d = FLUSH;
            FLUSH:   state_d = DRAIN;
            DRAIN:   if (res_last_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slot decode: what enters the slice pipeline on the next cycle.
    always_comb begin
        in_ready_o = (state_q == ISSUE);
        busy_o     = (state_q != IDLE);
        hs         = in_valid_i && (state_q == ISSUE);
        slot_a     = '0;
        slot_b     = '0;
        slot_ctrl  = '{opmode: OP_IDLE, c: '0, creg_en: 1'b0};
        slot_tag   = 1'b0;
        slot_last  = 1'b0;
        case (state_q)
            ISSUE: begin
                if (hs) begin
                    slot_a            = x_i;
                    slot_b            = y_q;
                    slot_ctrl.opmode  = (cnt_q == '0) ? OP_LIMB0 : OP_LIMBN;
                    slot_ctrl.c       = {17'b0, z_i};
                    slot_ctrl.creg_en = 1'b1;
                    slot_tag          = 1'b1;
                end else begin
                    slot_ctrl.opmode  = OP_BUBBLE;
                end
            end
            FLUSH: begin
                slot_ctrl.opmode = OP_FLUSH;
                slot_tag         = 1'b1;
                slot_last        = 1'b1;
            end
            default: ;
        endcase
    end

    // OPMODE/C trail A/B by the slice's AB+M depth minus its own OPMODE/C register.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            y_q       <= '0;
            cnt_q     <= '0;
            A_o       <= '0;
            B_o       <= '0;
            ctrl_pipe <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                y_q   <= y_i;
                cnt_q <= '0;
            end else if (hs) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            A_o          <= slot_a;
            B_o          <= slot_b;
            ctrl_pipe[0] <= slot_ctrl;
            for (int k = 1; k <= OP_DLY; k++) ctrl_pipe[k] <= ctrl_pipe[k-1];
            vld_pipe     <= {vld_pipe[STAGES-1:0], slot_tag};
            last_pipe    <= {last_pipe[STAGES-1:0], slot_last};
        end
    end

    assign OPMODE_o    = ctrl_pipe[OP_DLY].opmode;
    assign C_o         = ctrl_pipe[OP_DLY].c;
    assign CREG_en_o   = ctrl_pipe[OP_DLY].creg_en;
    assign res_valid_o = vld_pipe[STAGES];
    assign res_last_o  = vld_pipe[STAGES] & last_pipe[STAGES];
    assign done_o      = res_last_o;
    assign res_o       = P_i[16:0];
    assign unused_p_hi = ^P_i[33:17];

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Upstream control stage for one `DSP58_NOCASC_4A` slice. It computes R = X·y + Z over WORD_COUNT 17-bit limbs: it accepts X/Z limbs on a valid/ready stream and drives the slice's A/B/C/OPMODE/CREG_en ports so the DSP accumulates the inter-limb carry internally through its P>>17 feedback. It returns WORD_COUNT+1 result limbs taken from the slice's P output. It is the operand/control feeder for the FIOS row datapath.

## Interface
- WORD_COUNT, 8: limbs per operand (≥1)
- ABREG, 1: must match the slice's ABREG
- MREG, 1: must match the slice's MREG; ABREG+MREG ≥ 1 required (slice CREG fixed at 1)
- DSP_REG_LEVEL, localparam = 1+ABREG+MREG
- clock_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  start pulse; y_i is sampled here
- y_i  in  17  multiplier word
- busy_o  out  1  operation in progress
- in_valid_i / in_ready_o  in/out  1  X/Z limb handshake, LSB limb first
- x_i, z_i  in  17  limb j of X and Z
- A_o, B_o  out  17  to slice A_i/B_i
- C_o  out  34  to slice C_i
- CREG_en_o  out  1  to slice CREG_en_i
- OPMODE_o  out  9  to slice OPMODE_i
- P_i  in  34  from slice P_o
- res_valid_o  out  1  result limb valid
- res_o  out  17  result limb, equal to P_i[16:0]
- res_last_o  out  1  marks limb WORD_COUNT, the top carry
- done_o  out  1  one-cycle pulse with the last limb

## Operation
- FSM IDLE → ISSUE → FLUSH → DRAIN → IDLE.
- IDLE: start_i=1 latches y_i, clears the limb counter, and enters ISSUE. start_i is ignored while busy_o=1.
- ISSUE: in_ready_o=1. Each accepted handshake creates a LIMB slot, with counter j incrementing. After limb WORD_COUNT-1 is accepted, go to FLUSH. A cycle with no handshake creates a BUBBLE slot.
- FLUSH: one FLUSH slot, then DRAIN.
- DRAIN: wait until the FLUSH result has been emitted, then IDLE. busy_o is 1 in ISSUE, FLUSH and DRAIN.
- Slot encodings (OPMODE = W[8:7] Z[6:4] Y[3:2] X[1:0]):
  - LIMB j=0: 9'h185 (M + C)
  - LIMB j>0: 9'h1E5 (M + C + P>>17)
  - BUBBLE: 9'h020 (P held)
  - FLUSH: 9'h060 (P>>17 only)
  - Idle/no slot: 9'h000
- LIMB slot outputs: A_o=x_j, B_o=y, C_o={17'b0,z_j}, CREG_en_o=1. All other slots drive A_o=B_o=0, C_o=0, CREG_en_o=0.
- Width rule: x·y + z + carry ≤ 2^34−1, so P never overflows 34 bits. Carry < 2^17.
- Result: LIMB and FLUSH slots carry a valid tag. BUBBLE and idle slots do not.
  - res_valid_o=1 when a tagged slot's P arrives.
  - res_last_o and done_o are 1 for the FLUSH result only.
- Limbs are emitted in order 0..WORD_COUNT. There is no output backpressure.

## Timing
- All DSP-driving outputs are registered. A handshake in cycle t puts A_o/B_o in cycle t+1, the slot cycle s.
- OPMODE_o, C_o and CREG_en_o for slot s are presented in cycle s+DSP_REG_LEVEL−2. This aligns them with the slice's internal OPMODE/C registers and the M register.
- P for slot s is valid in cycle s+DSP_REG_LEVEL. res_valid_o, res_last_o and done_o are asserted in that cycle.
- Minimum latency, start to done, is WORD_COUNT+DSP_REG_LEVEL+2 cycles with in_valid_i held high.
- Reset values: busy_o=0, in_ready_o=0, A_o=B_o=0, C_o=0, CREG_en_o=0, OPMODE_o=9'h000, res_valid_o=0, res_last_o=0, done_o=0. FSM in IDLE, y register and counter cleared, tag pipeline cleared.
- Reset asserted mid-operation aborts immediately. No result is emitted afterwards, and the slice's P contents are don't-care. The next start_i after release runs normally; its first limb uses OPMODE 9'h185, so stale P is discarded.
- start_i and the final result in the same cycle (DRAIN→IDLE): start_i is ignored.

## Test plan
- WORD_COUNT=2, y=3, X={5,7}, Z={1,2}, in_valid_i held high -> res_o 16, 23, 0. res_last_o on the third limb. done_o at start+WORD_COUNT+DSP_REG_LEVEL+2.
- WORD_COUNT=2, y=0x1FFFF, X={0x1FFFF,0x1FFFF}, Z={0x1FFFF,0x1FFFF} -> res_o 0x00000, 0x1FFFF, 0x1FFFF. No overflow.
- Same operands as the first case, with in_valid_i low for 3 cycles between limbs -> 9'h020 issued for each bubble. Results identical. Valid gaps match the bubbles.
- start_i pulsed during ISSUE with a different y_i -> ignored. Results use the original y.
- reset_n_i low for 1 cycle mid-ISSUE -> all outputs at reset values next cycle, no res_valid_o. A following run of the first case gives 16, 23, 0.
- WORD_COUNT=1, y=2, X={0x10000}, Z={0} -> res_o 0x00000, 0x00001.
